dct_approx_stream: RTL and testbench

//  Streaming, parametrised successor to the 2-point DCT approximation.

---
 rtl/dct_approx_pkg.sv | 37 +++
 rtl/dct_approx_stream_bfly.sv | 41 ++++
 rtl/dct_approx_stream.sv | 130 +++++++++++++
 tb/tb_dct_approx_stream.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dct_approx_pkg.sv
// Shared types and index helpers for the streaming
// Walsh-Hadamard (multiplier-free DCT approximation) block.
package dct_approx_pkg;

   typedef enum logic [1:0] {
      COLLECT,
      COMPUTE,
      OUTPUT
   } state_t;

   // Widest coefficient index supported (N up to 16)
   localparam int MAX_LOG2N = 4;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   // Sequency index -> natural Hadamard row:
   // gray code, then reverse the low log2n bits.
   function automatic logic [MAX_LOG2N-1:0] seq_to_nat(
      input logic [MAX_LOG2N-1:0] k,
      input int                   log2n
   );
      logic [MAX_LOG2N-1:0] g;
      logic [MAX_LOG2N-1:0] r;
      g = k ^ (k >> 1);
      r = '0;
      for (int i = 0; i < MAX_LOG2N; i++)
         if (i < log2n) r[i] = g[log2n-1-i];
      return r;
   endfunction

endpackage

// File: rtl/dct_approx_stream_bfly.sv
// One radix-2 Hadamard butterfly stage over the flat
// coefficient buffer; the stage input picks the span 2^s.
module wht_butterfly_stage #(
   parameter int N     = 8,
   parameter int OUT_W = 11,
   parameter int LOG2N = 3
)(
   input  logic [N*OUT_W-1:0] i_buf,
   input  logic [LOG2N-1:0]   i_stage,
   output logic [N*OUT_W-1:0] o_buf
);

   logic signed [OUT_W-1:0] w_in  [N];
   logic signed [OUT_W-1:0] w_stg [LOG2N][N];
   logic signed [OUT_W-1:0] w_sel [N];

   for (genvar i = 0; i < N; i++) begin : g_io
      assign w_in[i] = i_buf[i*OUT_W +: OUT_W];
      assign o_buf[i*OUT_W +: OUT_W] = w_sel[i];
   end

   // Every stage is built statically; the pair partner is
   // resolved at elaboration, so no index ever leaves 0..N-1.
   for (genvar s = 0; s < LOG2N; s++) begin : g_stg
      for (genvar i = 0; i < N; i++) begin : g_el
         if (((i >> s) & 1) == 0) begin : g_sum
            assign w_stg[s][i] = w_in[i] + w_in[i+(1<<s)];
         end else begin : g_dif
            assign w_stg[s][i] = w_in[i-(1<<s)] - w_in[i];
         end
      end
   end

   // select the active stage result
   always_comb begin
      w_sel = w_stg[0];
      for (int s = 1; s < LOG2N; s++)
         if (32'(i_stage) == s) w_sel = w_stg[s];
   end

endmodule

// File: rtl/dct_approx_stream.sv
// Streaming N-point Walsh-Hadamard transform: collect N pixels,
// one butterfly stage per clock, then stream N coefficients.
module dct_approx_stream
   import dct_approx_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int N      = 8,
   parameter  int ORDER  = 1,
   localparam int LOG2N  = clog2(N),
   localparam int OUT_W  = DATA_W + LOG2N
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pixel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_coef,
   output logic [LOG2N-1:0]  out_idx,
   output logic              out_last,
   output logic              busy
);

   localparam logic [LOG2N-1:0] LAST_CNT = LOG2N'(N - 1);
   localparam logic [LOG2N-1:0] LAST_STG = LOG2N'(LOG2N - 1);

   state_t                  r_state;
   state_t                  w_next;
   logic [LOG2N-1:0]        r_cnt;
   logic [LOG2N-1:0]        r_stage;
   logic [LOG2N-1:0]        r_idx;
   logic signed [OUT_W-1:0] r_buf [N];

   logic [N*OUT_W-1:0]      w_flat;
   logic [N*OUT_W-1:0]      w_nxt;
   logic [LOG2N-1:0]        w_row;
   logic signed [OUT_W-1:0] w_ext;
   logic                    w_in_hs;
   logic                    w_out_hs;

   assign w_ext = {{LOG2N{in_pixel[DATA_W-1]}}, in_pixel};
   assign w_in_hs  = in_valid & in_ready;
   assign w_out_hs = out_valid & out_ready;

   for (genvar i = 0; i < N; i++) begin : g_flat
      assign w_flat[i*OUT_W +: OUT_W] = r_buf[i];
   end

   wht_butterfly_stage #(
      .N     (N),
      .OUT_W (OUT_W),
      .LOG2N (LOG2N)
   ) u_bfly (
      .i_buf   (w_flat),
      .i_stage (r_stage),
      .o_buf   (w_nxt)
   );

   // map output index to the natural Hadamard row
   always_comb begin
      w_row = r_idx;
      if (ORDER == 1)
         w_row = LOG2N'(seq_to_nat(MAX_LOG2N'(r_idx), LOG2N));
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= COLLECT;
      else        r_state <= w_next;
   end

   // next state and handshake/status outputs
   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (r_state)
         COLLECT: begin
            in_ready = 1'b1;
            if (in_valid && r_cnt == LAST_CNT)
               w_next = COMPUTE;
         end
         COMPUTE: begin
            busy = 1'b1;
            if (r_stage == LAST_STG)
               w_next = OUTPUT;
         end
         OUTPUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready && r_idx == LAST_CNT)
               w_next = COLLECT;
         end
         default: w_next = COLLECT;
      endcase
   end

   assign out_coef = out_valid ? r_buf[w_row] : '0;
   assign out_idx  = r_idx;
   assign out_last = out_valid && (r_idx == LAST_CNT);

   // pixel, stage and output index counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_stage <= '0;
         r_idx   <= '0;
      end else begin
         if (w_in_hs)
            r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
         if (r_state == COMPUTE)
            r_stage <= (r_stage == LAST_STG) ? '0 : r_stage + 1'b1;
         if (w_out_hs)
            r_idx <= (r_idx == LAST_CNT) ? '0 : r_idx + 1'b1;
      end
   end

   // pixel capture, then in-place butterfly per compute cycle
   always_ff @(posedge clk) begin
      if (w_in_hs) begin
         r_buf[r_cnt] <= w_ext;
      end else if (r_state == COMPUTE) begin
         for (int i = 0; i < N; i++)
            r_buf[i] <= w_nxt[i*OUT_W +: OUT_W];
      end
   end

endmodule

// File: tb/tb_dct_approx_stream.sv
// Directed bench for dct_approx_stream: N=2 natural, N=8
// sequency and N=8 natural instances share one stimulus path.
module tb_dct_approx_stream;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  pix = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   int          sel = 1;
   int          checks = 0;
   int          failures = 0;

   logic        v0, v1, v2;
   logic        rdy0, rdy1, rdy2;
   logic        ov0, ov1, ov2;
   logic        ol0, ol1, ol2;
   logic        bs0, bs1, bs2;
   logic [8:0]  c0;
   logic [10:0] c1, c2;
   logic [0:0]  i0;
   logic [2:0]  i1, i2;

   logic               o_rdy, o_valid, o_last, o_busy;
   logic signed [31:0] o_coef;
   logic [31:0]        o_idx;

   always #5 clk = ~clk;

   assign v0 = in_valid && (sel == 0);
   assign v1 = in_valid && (sel == 1);
   assign v2 = in_valid && (sel == 2);

   dct_approx_stream #(.DATA_W(8), .N(2), .ORDER(0)) u_n2 (
      .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0),
      .in_pixel(pix), .out_valid(ov0), .out_ready(out_ready),
      .out_coef(c0), .out_idx(i0), .out_last(ol0), .busy(bs0)
   );

   dct_approx_stream #(.DATA_W(8), .N(8), .ORDER(1)) u_s8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
      .in_pixel(pix), .out_valid(ov1), .out_ready(out_ready),
      .out_coef(c1), .out_idx(i1), .out_last(ol1), .busy(bs1)
   );

   dct_approx_stream #(.DATA_W(8), .N(8), .ORDER(0)) u_h8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
      .in_pixel(pix), .out_valid(ov2), .out_ready(out_ready),
      .out_coef(c2), .out_idx(i2), .out_last(ol2), .busy(bs2)
   );

   // route the selected instance to the observation signals
   always_comb begin
      o_rdy   = rdy0;
      o_valid = ov0;
      o_last  = ol0;
      o_busy  = bs0;
      o_coef  = {{23{c0[8]}}, c0};
      o_idx   = {31'b0, i0};
      if (sel == 1) begin
         o_rdy   = rdy1;
         o_valid = ov1;
         o_last  = ol1;
         o_busy  = bs1;
         o_coef  = {{21{c1[10]}}, c1};
         o_idx   = {29'b0, i1};
      end else if (sel == 2) begin
         o_rdy   = rdy2;
         o_valid = ov2;
         o_last  = ol2;
         o_busy  = bs2;
         o_coef  = {{21{c2[10]}}, c2};
         o_idx   = {29'b0, i2};
      end
   end

   task automatic chk(input string tag,
                      input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_blk(input int px[8], input int n, input int gap);
      for (int j = 0; j < n; j++) begin
         int t;
         t = 0;
         pix = 8'(px[j]);
         in_valid = 1'b1;
         while (!o_rdy && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t >= 50) chk("push_timeout", t, 0);
         @(negedge clk);
         in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic get_blk(input string tag, input int exp[8],
                          input int n, input int lat,
                          input int stall_at);
      int t;
      t = 0;
      while (!o_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (lat >= 0) chk({tag, "_lat"}, t, lat);
      for (int k = 0; k < n; k++) begin
         t = 0;
         while (!o_valid && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t >= 50) chk({tag, "_timeout"}, t, 0);
         if (k == stall_at) begin
            out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               chk($sformatf("%s_hold_coef%0d", tag, k), o_coef, exp[k]);
               chk($sformatf("%s_hold_idx%0d", tag, k), o_idx, k);
               chk($sformatf("%s_hold_rdy%0d", tag, k), o_rdy, 0);
            end
            out_ready = 1'b1;
         end
         chk($sformatf("%s_coef%0d", tag, k), o_coef, exp[k]);
         chk($sformatf("%s_idx%0d", tag, k), o_idx, k);
         chk($sformatf("%s_last%0d", tag, k), o_last, (k == n - 1) ? 1 : 0);
         chk($sformatf("%s_inrdy%0d", tag, k), o_rdy, 0);
         chk($sformatf("%s_busy%0d", tag, k), o_busy, 1);
         @(negedge clk);
      end
      chk({tag, "_done_rdy"}, o_rdy, 1);
      chk({tag, "_done_busy"}, o_busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int px[8];
      int ex[8];

      // reset state
      sel = 1;
      #12;
      chk("rst_inrdy", o_rdy, 1);
      chk("rst_valid", o_valid, 0);
      chk("rst_coef", o_coef, 0);
      chk("rst_idx", o_idx, 0);
      chk("rst_last", o_last, 0);
      chk("rst_busy", o_busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // N=2 natural
      sel = 0;
      px = '{50, 30, 0, 0, 0, 0, 0, 0};
      ex = '{80, 20, 0, 0, 0, 0, 0, 0};
      push_blk(px, 2, 0);
      get_blk("n2a", ex, 2, 1, -1);
      px = '{100, 40, 0, 0, 0, 0, 0, 0};
      ex = '{140, 60, 0, 0, 0, 0, 0, 0};
      push_blk(px, 2, 0);
      get_blk("n2b", ex, 2, 1, -1);

      // N=8 sequency, constant input
      sel = 1;
      px = '{10, 10, 10, 10, 10, 10, 10, 10};
      ex = '{80, 0, 0, 0, 0, 0, 0, 0};
      push_blk(px, 8, 0);
      get_blk("dc10", ex, 8, 3, -1);

      // alternating input: highest sequency / natural row 1
      px = '{1, -1, 1, -1, 1, -1, 1, -1};
      ex = '{0, 0, 0, 0, 0, 0, 0, 8};
      push_blk(px, 8, 0);
      get_blk("alt_seq", ex, 8, 3, -1);
      sel = 2;
      ex = '{0, 8, 0, 0, 0, 0, 0, 0};
      push_blk(px, 8, 0);
      get_blk("alt_nat", ex, 8, 3, -1);

      // extremes, no wrap
      sel = 1;
      px = '{-128, -128, -128, -128, -128, -128, -128, -128};
      ex = '{-1024, 0, 0, 0, 0, 0, 0, 0};
      push_blk(px, 8, 0);
      get_blk("min", ex, 8, 3, -1);
      px = '{127, 127, 127, 127, 127, 127, 127, 127};
      ex = '{1016, 0, 0, 0, 0, 0, 0, 0};
      push_blk(px, 8, 0);
      get_blk("max", ex, 8, 3, -1);

      // ramp with back-pressure on coefficient 3
      px = '{0, 1, 2, 3, 4, 5, 6, 7};
      ex = '{28, -16, 0, -8, 0, 0, 0, -4};
      push_blk(px, 8, 0);
      get_blk("stall", ex, 8, 3, 3);

      // reset after 5 pixels, then a clean block with gaps
      px = '{100, 100, 100, 100, 100, 0, 0, 0};
      push_blk(px, 5, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_inrdy", o_rdy, 1);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_valid", o_valid, 0);
      chk("mid_rst_coef", o_coef, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      px = '{1, 2, 3, 4, 5, 6, 7, 8};
      ex = '{36, -16, 0, -8, 0, 0, 0, -4};
      push_blk(px, 8, 1);
      get_blk("post_rst", ex, 8, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
